// File: rtl/cpu_19bit.sv
// Single-cycle 19-bit CPU: 16-entry register file, 1K-word data memory and a
// 16-deep return stack; every instruction commits on the rising clk edge.
module cpu_19bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] instruction,
  output logic [18:0] result
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_INC  = 5'd4,
    OP_DEC  = 5'd5,
    OP_AND  = 5'd6,
    OP_OR   = 5'd7,
    OP_XOR  = 5'd8,
    OP_NOT  = 5'd9,
    OP_JMP  = 5'd10,
    OP_BEQ  = 5'd11,
    OP_BNE  = 5'd12,
    OP_CALL = 5'd13,
    OP_RET  = 5'd14,
    OP_LD   = 5'd15,
    OP_ST   = 5'd16
  } op_e;

  logic [18:0] gen_pur_register [0:15];
  logic [18:0] memory [0:1023];
  logic [13:0] stack [0:15];
  logic [13:0] pc;
  logic [3:0]  sp;
  logic [18:0] result_q;

  op_e         op;
  logic [3:0]  ra, rb, rc;
  logic [13:0] tgt14;
  logic [5:0]  tgt6;
  logic [9:0]  addr10;
  logic [18:0] a_val, b_val, c_val;

  logic [13:0] pc_d, pc_inc;
  logic [3:0]  sp_d;
  logic [18:0] result_d;
  logic        reg_we, mem_we, stack_we;
  logic [18:0] reg_wdata;

  assign op     = op_e'(instruction[18:14]);
  assign ra     = instruction[13:10];
  assign rb     = instruction[9:6];
  assign rc     = instruction[5:2];
  assign tgt14  = instruction[13:0];
  assign tgt6   = instruction[5:0];
  assign addr10 = instruction[9:0];

  assign a_val  = gen_pur_register[ra];
  assign b_val  = gen_pur_register[rb];
  assign c_val  = gen_pur_register[rc];
  assign pc_inc = pc + 14'd1;
  assign result = result_q;

  always_comb begin
    pc_d      = pc_inc;
    sp_d      = sp;
    result_d  = result_q;
    reg_we    = 1'b0;
    reg_wdata = '0;
    mem_we    = 1'b0;
    stack_we  = 1'b0;
    case (op)
      OP_ADD: begin reg_we = 1'b1; reg_wdata = b_val + c_val; end
      OP_SUB: begin reg_we = 1'b1; reg_wdata = b_val - c_val; end
      OP_MUL: begin reg_we = 1'b1; reg_wdata = b_val * c_val; end
      OP_DIV: begin
        reg_we    = 1'b1;
        reg_wdata = (c_val == '0) ? '1 : b_val / c_val;
      end
      OP_INC: begin reg_we = 1'b1; reg_wdata = a_val + 19'd1; end
      OP_DEC: begin reg_we = 1'b1; reg_wdata = a_val - 19'd1; end
      OP_AND: begin reg_we = 1'b1; reg_wdata = b_val & c_val; end
      OP_OR:  begin reg_we = 1'b1; reg_wdata = b_val | c_val; end
      OP_XOR: begin reg_we = 1'b1; reg_wdata = b_val ^ c_val; end
      OP_NOT: begin reg_we = 1'b1; reg_wdata = ~b_val; end
      OP_JMP: pc_d = tgt14;
      OP_BEQ: if (a_val == b_val) pc_d = {8'd0, tgt6};
      OP_BNE: if (a_val != b_val) pc_d = {8'd0, tgt6};
      OP_CALL: begin
        stack_we = 1'b1;
        sp_d     = sp + 4'd1;
        pc_d     = tgt14;
      end
      OP_RET: begin
        sp_d = sp - 4'd1;
        pc_d = stack[sp_d];
      end
      OP_LD: begin reg_we = 1'b1; reg_wdata = memory[addr10]; end
      OP_ST: begin mem_we = 1'b1; result_d = a_val; end
      default: ;
    endcase
    // Register writes and control flow each report their own value on result
    if (reg_we) result_d = reg_wdata;
    if (op inside {OP_JMP, OP_BEQ, OP_BNE, OP_CALL, OP_RET}) result_d = {5'd0, pc_d};
  end

  // Memory and stack sit in the reset branch's else so a write on an edge
  // where rst is low is aborted, yet their contents are never cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= '0;
      sp       <= '0;
      result_q <= '0;
      for (int unsigned i = 0; i < 16; i++) gen_pur_register[i] <= '0;
    end else begin
      pc       <= pc_d;
      sp       <= sp_d;
      result_q <= result_d;
      if (reg_we)   gen_pur_register[ra] <= reg_wdata;
      if (mem_we)   memory[addr10]       <= a_val;
      if (stack_we) stack[sp]            <= pc_inc;
    end
  end

endmodule

// File: tb/tb_cpu_19bit.sv
// Directed bench for cpu_19bit: table of ALU vectors plus hand-written
// control-flow, stack-wrap, memory and reset sequences.
module tb_cpu_19bit;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,
                         OP_DIV = 5'd3,  OP_INC = 5'd4,  OP_DEC = 5'd5,
                         OP_AND = 5'd6,  OP_OR  = 5'd7,  OP_XOR = 5'd8,
                         OP_NOT = 5'd9,  OP_JMP = 5'd10, OP_BEQ = 5'd11,
                         OP_BNE = 5'd12, OP_CALL = 5'd13, OP_RET = 5'd14,
                         OP_LD  = 5'd15, OP_ST  = 5'd16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [18:0] instruction = '0;
  logic [18:0] result;

  int tests = 0;
  int fails = 0;

  cpu_19bit dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .result      (result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [18:0] instr;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl [0:14];

  function automatic logic [18:0] rrr(logic [4:0] op, logic [3:0] ra, logic [3:0] rb, logic [3:0] rc);
    return {op, ra, rb, rc, 2'b00};
  endfunction

  function automatic logic [18:0] br(logic [4:0] op, logic [3:0] ra, logic [3:0] rb, logic [5:0] t6);
    return {op, ra, rb, t6};
  endfunction

  function automatic logic [18:0] jt(logic [4:0] op, logic [13:0] t14);
    return {op, t14};
  endfunction

  function automatic logic [18:0] mem(logic [4:0] op, logic [3:0] ra, logic [9:0] a10);
    return {op, ra, a10};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exec(input logic [18:0] instr);
    instruction = instr;
    @(posedge clk);
    #1;
  endtask

  // Builds a constant purely from instructions: clear, then shift-and-increment.
  task automatic load_const(input logic [3:0] r, input logic [18:0] v);
    exec(rrr(OP_XOR, r, r, r));
    for (int b = 18; b >= 0; b--) begin
      exec(rrr(OP_ADD, r, r, r));
      if (v[b]) exec(rrr(OP_INC, r, 4'd0, 4'd0));
    end
  endtask

  task automatic check_pc(input string name, input logic [13:0] exp);
    check(name, {5'd0, dut.pc}, {5'd0, exp});
  endtask

  task automatic check_sp(input string name, input logic [3:0] exp);
    check(name, {15'd0, dut.sp}, {15'd0, exp});
  endtask

  initial begin
    logic [13:0] pc_before;
    logic [3:0]  ra;

    tbl[0]  = '{rrr(OP_ADD, 4'd0,  4'd1,  4'd2),  19'd15};
    tbl[1]  = '{rrr(OP_SUB, 4'd12, 4'd4,  4'd5),  19'd8};
    tbl[2]  = '{rrr(OP_MUL, 4'd13, 4'd6,  4'd7),  19'd12};
    tbl[3]  = '{rrr(OP_DIV, 4'd14, 4'd8,  4'd7),  19'd5};
    tbl[4]  = '{rrr(OP_DIV, 4'd14, 4'd8,  4'd9),  19'h7FFFF};
    tbl[5]  = '{rrr(OP_INC, 4'd3,  4'd0,  4'd0),  19'd0};
    tbl[6]  = '{rrr(OP_DEC, 4'd11, 4'd0,  4'd0),  19'h7FFFF};
    tbl[7]  = '{rrr(OP_MUL, 4'd12, 4'd11, 4'd11), 19'd1};
    tbl[8]  = '{rrr(OP_ADD, 4'd1,  4'd1,  4'd1),  19'd10};
    tbl[9]  = '{rrr(OP_SUB, 4'd0,  4'd9,  4'd1),  19'h7FFF6};
    tbl[10] = '{rrr(OP_AND, 4'd2,  4'd15, 4'd10), 19'd0};
    tbl[11] = '{rrr(OP_OR,  4'd2,  4'd15, 4'd10), 19'h7FFFF};
    tbl[12] = '{rrr(OP_XOR, 4'd2,  4'd15, 4'd10), 19'h7FFFF};
    tbl[13] = '{rrr(OP_NOT, 4'd2,  4'd15, 4'd0),  19'h2AAAA};
    tbl[14] = '{rrr(OP_DIV, 4'd13, 4'd15, 4'd10), 19'd2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 19'd0);
    check_pc("reset_pc", 14'd0);
    check_sp("reset_sp", 4'd0);
    @(negedge clk);
    rst = 1'b1;

    // Operand setup
    load_const(4'd1, 19'd5);
    load_const(4'd2, 19'd10);
    load_const(4'd4, 19'd15);
    load_const(4'd5, 19'd7);
    load_const(4'd6, 19'd3);
    load_const(4'd7, 19'd4);
    load_const(4'd8, 19'd20);
    load_const(4'd9, 19'd0);
    load_const(4'd3, 19'h7FFFF);
    load_const(4'd11, 19'd0);
    load_const(4'd15, 19'h55555);
    load_const(4'd10, 19'h2AAAA);
    check("setup_r15", dut.gen_pur_register[15], 19'h55555);

    // ALU table
    for (int i = 0; i < 15; i++) begin
      pc_before = dut.pc;
      ra = tbl[i].instr[13:10];
      exec(tbl[i].instr);
      check($sformatf("alu%0d_result", i), result, tbl[i].exp);
      check($sformatf("alu%0d_reg", i), dut.gen_pur_register[ra], tbl[i].exp);
      check_pc($sformatf("alu%0d_pc", i), pc_before + 14'd1);
    end

    // NOPs: result and registers hold, pc advances
    pc_before = dut.pc;
    exec({5'd17, 14'h3FFF});
    exec({5'd31, 14'h0F3C});
    check("nop_result", result, 19'd2);
    check("nop_r15", dut.gen_pur_register[15], 19'h55555);
    check_pc("nop_pc", pc_before + 14'd2);

    // Control flow (R1=10, R8=20)
    exec(jt(OP_JMP, 14'd20));
    check_pc("jmp_pc", 14'd20);
    check("jmp_result", result, 19'd20);
    exec(br(OP_BEQ, 4'd1, 4'd1, 6'd30));
    check_pc("beq_taken_pc", 14'd30);
    exec(br(OP_BNE, 4'd1, 4'd1, 6'd40));
    check_pc("bne_not_taken_pc", 14'd31);
    check("bne_not_taken_result", result, 19'd31);
    exec(br(OP_BEQ, 4'd1, 4'd8, 6'd5));
    check_pc("beq_not_taken_pc", 14'd32);
    exec(br(OP_BNE, 4'd1, 4'd8, 6'd40));
    check_pc("bne_taken_pc", 14'd40);
    exec(jt(OP_CALL, 14'd50));
    check_pc("call_pc", 14'd50);
    check_sp("call_sp", 4'd1);
    check("call_result", result, 19'd50);
    exec(jt(OP_RET, 14'd0));
    check_pc("ret_pc", 14'd41);
    check_sp("ret_sp", 4'd0);
    check("ret_result", result, 19'd41);

    // Stack overflow and underflow wrap
    for (int i = 0; i < 16; i++) exec(jt(OP_CALL, 14'(100 + i)));
    check_sp("call16_sp_wrap", 4'd0);
    exec(jt(OP_CALL, 14'd116));
    check_sp("call17_sp", 4'd1);
    check_pc("call17_pc", 14'd116);
    exec(jt(OP_RET, 14'd0));
    check_pc("ret_overwritten_pc", 14'd116);
    exec(jt(OP_RET, 14'd0));
    check_sp("ret_underflow_sp", 4'd15);
    check_pc("ret_underflow_pc", 14'd115);

    // Memory
    load_const(4'd3, 19'd1234);
    exec(mem(OP_ST, 4'd3, 10'd60));
    check("st60_mem", dut.memory[60], 19'd1234);
    pc_before = dut.pc;
    exec(mem(OP_LD, 4'd1, 10'd60));
    check("ld_r1", dut.gen_pur_register[1], 19'd1234);
    check("ld_result", result, 19'd1234);
    check_pc("ld_pc", pc_before + 14'd1);
    load_const(4'd2, 19'd5678);
    pc_before = dut.pc;
    exec(mem(OP_ST, 4'd2, 10'd70));
    check("st70_mem", dut.memory[70], 19'd5678);
    check("st70_result", result, 19'd5678);
    check_pc("st_pc", pc_before + 14'd1);

    // Asynchronous reset mid-run, then an edge while held low
    #3;
    rst = 1'b0;
    #1;
    check("midrst_result", result, 19'd0);
    check_pc("midrst_pc", 14'd0);
    check_sp("midrst_sp", 4'd0);
    for (int i = 0; i < 16; i++)
      check($sformatf("midrst_r%0d", i), dut.gen_pur_register[i], 19'd0);
    check("midrst_mem_kept", dut.memory[70], 19'd5678);
    instruction = mem(OP_ST, 4'd3, 10'd70);
    @(posedge clk);
    #1;
    check("rst_edge_mem_abort", dut.memory[70], 19'd5678);
    check_pc("rst_edge_pc", 14'd0);
    @(negedge clk);
    rst = 1'b1;
    exec(rrr(OP_INC, 4'd3, 4'd0, 4'd0));
    check("post_rst_r3", dut.gen_pur_register[3], 19'd1);
    check("post_rst_result", result, 19'd1);
    check_pc("post_rst_pc", 14'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
